// File: rtl/vert_avg_accum.sv
// vert_avg_accum: vertical accumulator ahead of vert_avg_output.
// Each accepted pixel is added into the shared sum buffer at its column.
// After ROWS_PER_BIN rows, or at end of frame, the block requests a flush.
// While req is high, vert_avg_output owns the buffer, emits it and clears it.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_ACCUM   | accepting pixels, read-modify-writing column sums
// ST_DRAIN   | one cycle so the last pipelined write retires
// ST_FLUSH   | req high, buffer handed to vert_avg_output, wait for ack
// ST_RELEASE | req dropped, wait for ack to fall before resuming
module vert_avg_accum #(
  parameter int COLS         = 28,
  parameter int ROWS_PER_BIN = 4,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] pix_i,
  input  logic              pix_valid,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic [4:0]        sum_raddr,
  input  logic [23:0]       sum_rdata,
  output logic [4:0]        sum_waddr,
  output logic [23:0]       sum_wdata,
  output logic              sum_we,
  output logic              req,
  input  logic              ack,
  output logic              short_err
);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [4:0] COL_LAST = 5'(COLS - 1);
  localparam logic [7:0] ROW_LAST = 8'(ROWS_PER_BIN - 1);

  logic [1:0]        state_q, state_d;
  logic [4:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic              short_err_q, short_err_d;
  logic              pix_ready_q;
  logic              req_q;
  logic [DATA_W-1:0] s1_pix_q;
  logic [4:0]        s1_col_q;
  logic              s1_valid_q;

  logic beat;
  logic bin_end;

  // pix_ready_q is only ever high in ST_ACCUM, so a beat implies ST_ACCUM
  assign beat    = pix_valid & pix_ready_q;
  assign bin_end = beat & (pix_last | ((col_q == COL_LAST) & (row_q == ROW_LAST)));

  // Next-state logic: FSM sequencing plus column/row position tracking
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    short_err_d = short_err_q;
    case (state_q)
      ST_ACCUM: begin
        if (beat) begin
          if (pix_last && (col_q != COL_LAST)) short_err_d = 1'b1;
          if (bin_end) begin
            state_d = ST_DRAIN;
            col_d   = '0;
            row_d   = '0;
          end else if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 8'd1;
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      ST_DRAIN:   state_d = ST_FLUSH;
      ST_FLUSH:   if (ack) state_d = ST_RELEASE;
      ST_RELEASE: if (!ack) state_d = ST_ACCUM;
      default:    state_d = ST_ACCUM;
    endcase
  end

  // Control registers; req and pix_ready are registered images of the next state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_ACCUM;
      col_q       <= '0;
      row_q       <= '0;
      short_err_q <= 1'b0;
      pix_ready_q <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      short_err_q <= short_err_d;
      pix_ready_q <= (state_d == ST_ACCUM);
      req_q       <= (state_d == ST_FLUSH);
    end
  end

  // One-deep pipeline stage holding the accepted pixel and its column
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_pix_q   <= '0;
      s1_col_q   <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= beat;
      if (beat) begin
        s1_pix_q <= pix_i;
        s1_col_q <= col_q;
      end
    end
  end

  // Read-modify-write: combinational read, add with 24-bit wrap, write at next edge.
  // Adjacent beats always target different columns, so no forwarding is needed.
  assign sum_raddr = s1_valid_q ? s1_col_q : 5'd0;
  assign sum_waddr = s1_col_q;
  assign sum_wdata = sum_rdata + 24'(s1_pix_q);
  assign sum_we    = s1_valid_q;

  assign pix_ready = pix_ready_q;
  assign req       = req_q;
  assign short_err = short_err_q;

endmodule

// File: tb/tb_vert_avg_accum.sv
// Self-checking bench for vert_avg_accum: models the sum buffer and the flush
// partner, predicts every buffer write in a scoreboard queue.
module tb_vert_avg_accum;

  localparam int COLS = 28;
  localparam int ROWS = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] pix_i;
  logic        pix_valid;
  logic        pix_last;
  logic        pix_ready;
  logic [4:0]  sum_raddr;
  logic [23:0] sum_rdata;
  logic [4:0]  sum_waddr;
  logic [23:0] sum_wdata;
  logic        sum_we;
  logic        req;
  logic        ack;
  logic        short_err;

  vert_avg_accum #(.COLS(COLS), .ROWS_PER_BIN(ROWS), .DATA_W(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pix_i     (pix_i),
    .pix_valid (pix_valid),
    .pix_last  (pix_last),
    .pix_ready (pix_ready),
    .sum_raddr (sum_raddr),
    .sum_rdata (sum_rdata),
    .sum_waddr (sum_waddr),
    .sum_wdata (sum_wdata),
    .sum_we    (sum_we),
    .req       (req),
    .ack       (ack),
    .short_err (short_err)
  );

  always #5 clk = ~clk;

  logic [23:0] mem     [32];
  logic [23:0] ref_mem [32];
  assign sum_rdata = mem[sum_raddr];

  typedef struct packed {
    logic [4:0]  addr;
    logic [23:0] data;
  } wr_t;
  wr_t sb_q[$];

  typedef struct {
    logic [23:0] preset;
    logic [15:0] pix;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[4];

  int errors = 0;
  int checks = 0;
  int col_m  = 0;
  int row_m  = 0;
  bit short_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Advance to the next negedge and service the buffer write port
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (resetn && sum_we) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%06h, required no write", sum_waddr, sum_wdata);
      end else begin
        e = sb_q.pop_front();
        check("wr_addr",  32'(sum_waddr), 32'(e.addr));
        check("wr_raddr", 32'(sum_raddr), 32'(e.addr));
        check("wr_data",  32'(sum_wdata), 32'(e.data));
      end
      mem[sum_waddr] = sum_wdata;
    end
  endtask

  // Present one pixel until accepted, updating the reference model on acceptance
  task automatic send(input logic [15:0] p, input logic last);
    int n;
    n = 0;
    pix_i = p;
    pix_last = last;
    pix_valid = 1'b1;
    while (!pix_ready && n < 200) begin
      tick();
      n++;
    end
    if (!pix_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: pix_ready=0 after %0d cycles, required 1", n);
      pix_valid = 1'b0;
      pix_last = 1'b0;
      return;
    end
    sb_q.push_back('{addr: 5'(col_m), data: ref_mem[col_m] + 24'(p)});
    ref_mem[col_m] = ref_mem[col_m] + 24'(p);
    if (last && col_m != COLS - 1) short_exp = 1'b1;
    if (last || (col_m == COLS - 1 && row_m == ROWS - 1)) begin
      col_m = 0;
      row_m = 0;
    end else if (col_m == COLS - 1) begin
      col_m = 0;
      row_m++;
    end else begin
      col_m++;
    end
    tick();
    pix_valid = 1'b0;
    pix_last = 1'b0;
  endtask

  // Play the flush partner: wait for req, optionally hold, check/clear buffer, handshake
  task automatic do_flush(input int hold, input bit poke);
    int n;
    n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    check("flush_req", 32'(req), 1);
    if (poke) begin
      pix_valid = 1'b1;
      pix_i = 16'h5555;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_req",   32'(req), 1);
      check("hold_ready", 32'(pix_ready), 0);
      check("hold_we",    32'(sum_we), 0);
    end
    pix_valid = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      check("flush_sum", 32'(mem[c]), 32'(ref_mem[c]));
      mem[c] = '0;
      ref_mem[c] = '0;
    end
    check("short_err", 32'(short_err), 32'(short_exp));
    ack = 1'b1;
    tick();
    check("ack_req_low",   32'(req), 0);
    check("release_ready", 32'(pix_ready), 0);
    ack = 1'b0;
    tick();
    check("resume_ready",  32'(pix_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int n;
    vecs[0] = '{preset: 24'hFFFFF0, pix: 16'hFFFF, exp: 24'h00FFEF};
    vecs[1] = '{preset: 24'h000000, pix: 16'h1234, exp: 24'h001234};
    vecs[2] = '{preset: 24'hFFFFFF, pix: 16'h0001, exp: 24'h000000};
    vecs[3] = '{preset: 24'h123456, pix: 16'hFFFF, exp: 24'h133455};

    for (int c = 0; c < 32; c++) begin
      mem[c] = '0;
      ref_mem[c] = '0;
    end
    resetn = 1'b0;
    pix_i = '0;
    pix_valid = 1'b0;
    pix_last = 1'b0;
    ack = 1'b0;

    // Reset state
    #2;
    check("rst_req",       32'(req), 0);
    check("rst_ready",     32'(pix_ready), 0);
    check("rst_we",        32'(sum_we), 0);
    check("rst_short_err", 32'(short_err), 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    tick();
    check("rel_ready", 32'(pix_ready), 1);

    // Full bin of unit pixels, then req latency
    for (int i = 0; i < COLS * ROWS; i++) send(16'd1, 1'b0);
    check("t1_sum_first", 32'(mem[0]), 32'h4);
    check("t1_sum_last",  32'(mem[COLS-1]), 32'h4);
    check("t1_req_drain", 32'(req), 0);
    check("t1_ready_off", 32'(pix_ready), 0);
    tick();
    check("t1_req_rise", 32'(req), 1);

    // Long flush with ack held low and pixels offered meanwhile
    do_flush(50, 1'b1);

    // Add wrap table
    for (int v = 0; v < 4; v++) begin
      mem[col_m] = vecs[v].preset;
      ref_mem[col_m] = vecs[v].preset;
      a = col_m;
      send(vecs[v].pix, 1'b0);
      check("vec_wdata", 32'(mem[a]), 32'(vecs[v].exp));
    end

    // Short row: pix_last on the 10th beat of row 0
    for (int i = 4; i < 10; i++) send(16'(i + 1), i == 9);
    check("t3_short_err", 32'(short_err), 1);
    do_flush(2, 1'b0);
    send(16'd7, 1'b0);

    // Reset asserted while in FLUSH
    send(16'd3, 1'b1);
    n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    check("t5_in_flush", 32'(req), 1);
    resetn = 1'b0;
    #1;
    check("t5_req",       32'(req), 0);
    check("t5_ready",     32'(pix_ready), 0);
    check("t5_short_err", 32'(short_err), 0);
    sb_q.delete();
    col_m = 0;
    row_m = 0;
    short_exp = 1'b0;
    for (int c = 0; c < 32; c++) begin
      mem[c] = '0;
      ref_mem[c] = '0;
    end
    repeat (3) tick();
    check("t5_ready_held", 32'(pix_ready), 0);
    resetn = 1'b1;
    tick();
    check("t5_ready_rel", 32'(pix_ready), 1);
    check("t5_req_rel",   32'(req), 0);

    // Three bins of random pixels with random valid gaps
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < COLS * ROWS; i++) begin
        n = int'($urandom_range(0, 2));
        repeat (n) tick();
        send(16'($urandom_range(0, 65535)), 1'b0);
      end
      do_flush(int'($urandom_range(0, 3)), 1'b0);
    end

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
